conv_stream_driver: RTL and testbench

CONV_STREAM_DRIVER -- requirements
Module: conv_stream_driver

---
 rtl/conv_stream_driver_if.sv | 25 ++
 rtl/conv_stream_driver.sv | 200 ++++++++++++++++++++
 tb/tb_conv_stream_driver.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_driver_if.sv
// Stream link between the driver and the convolution engine.
// master: drives pixel/weight beats, receives pooled results.
interface conv_stream_driver_if;
    logic        conv_in_valid;
    logic [15:0] conv_ifm;
    logic [15:0] conv_weight;
    logic        conv_out_valid;
    logic [35:0] conv_ofm;

    modport master (
        output conv_in_valid,
        output conv_ifm,
        output conv_weight,
        input  conv_out_valid,
        input  conv_ofm
    );

    modport slave (
        input  conv_in_valid,
        input  conv_ifm,
        input  conv_weight,
        output conv_out_valid,
        output conv_ofm
    );
endinterface

// File: rtl/conv_stream_driver.sv
// Frame driver: host loads IFM/weight stores, start streams one frame
// to the conv engine and captures pooled results into a readable store.
// Ports: clk, rst_n (async, active-low); host write wr_en/wr_sel/
// wr_addr/wr_data; start; conv (stream interface, master side);
// rd_addr/rd_data (1-cycle read of results); busy, done, err_timeout,
// res_count status.
module conv_stream_driver #(
    parameter int IFM_LEN = 196,
    parameter int W_LEN   = 9,
    parameter int OFM_LEN = 36,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic [7:0]                  wr_addr,
    input  logic [15:0]                 wr_data,
    input  logic                        start,
    conv_stream_driver_if.master        conv,
    input  logic [5:0]                  rd_addr,
    output logic [35:0]                 rd_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err_timeout,
    output logic [5:0]                  res_count
);

    localparam int IAW = $clog2(IFM_LEN);
    localparam int WAW = (W_LEN > 1) ? $clog2(W_LEN) : 1;
    localparam int RAW = $clog2(OFM_LEN);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [7:0]     IFM_N8 = 8'(IFM_LEN);
    localparam logic [7:0]     W_N8   = 8'(W_LEN);
    localparam logic [IAW-1:0] W_NK   = IAW'(W_LEN);
    localparam logic [IAW-1:0] LAST_K = IAW'(IFM_LEN - 1);
    localparam logic [5:0]     OFM_N  = 6'(OFM_LEN);
    localparam logic [TW-1:0]  TMO_N  = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IAW-1:0]  k_q, k_d;
    logic            vld_q, vld_d;
    logic [15:0]     ifm_q, ifm_d;
    logic [15:0]     wgt_q, wgt_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [35:0]     rd_q, rd_d;

    logic [15:0]     ifm_mem [IFM_LEN];
    logic [15:0]     w_mem   [W_LEN];
    logic [35:0]     res_mem [OFM_LEN];

    logic            in_frame;
    logic            cap;
    logic            we_ifm;
    logic            we_w;

    assign in_frame = (state_q == SEND) || (state_q == WAIT);
    assign cap      = in_frame && conv.conv_out_valid && (cnt_q < OFM_N);
    assign we_ifm   = (state_q == IDLE) && wr_en && !wr_sel
                      && (wr_addr < IFM_N8);
    assign we_w     = (state_q == IDLE) && wr_en && wr_sel
                      && (wr_addr < W_N8);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        vld_d   = 1'b0;
        cnt_d   = cap ? cnt_q + 6'd1 : cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    k_d     = '0;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            SEND: begin
                if (k_q == LAST_K) begin
                    // Results may already be complete; skip WAIT then.
                    state_d = (cnt_d == OFM_N) ? DONE : WAIT;
                    tmo_d   = '0;
                end else begin
                    k_d   = k_q + 1'b1;
                    vld_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_d == OFM_N) begin
                    state_d = DONE;
                end else if (cap) begin
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_N) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they follow the next state.
        ifm_d  = vld_d ? ifm_mem[k_d] : 16'd0;
        wgt_d  = (vld_d && (k_d < W_NK)) ? w_mem[k_d[WAW-1:0]] : 16'd0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        rd_d   = (rd_addr < OFM_N) ? res_mem[rd_addr[RAW-1:0]] : 36'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            vld_q   <= 1'b0;
            ifm_q   <= '0;
            wgt_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            vld_q   <= vld_d;
            ifm_q   <= ifm_d;
            wgt_q   <= wgt_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IFM_LEN; i++) begin
                ifm_mem[i] <= '0;
            end
        end else if (we_ifm) begin
            ifm_mem[wr_addr[IAW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W_LEN; i++) begin
                w_mem[i] <= '0;
            end
        end else if (we_w) begin
            w_mem[wr_addr[WAW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OFM_LEN; i++) begin
                res_mem[i] <= '0;
            end
        end else if (cap) begin
            res_mem[cnt_q[RAW-1:0]] <= conv.conv_ofm;
        end
    end

    assign conv.conv_in_valid = vld_q;
    assign conv.conv_ifm      = ifm_q;
    assign conv.conv_weight   = wgt_q;
    assign rd_data            = rd_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err_timeout        = err_q;
    assign res_count          = cnt_q;

endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench for conv_stream_driver: load, stream, capture,
// overflow, timeout, mid-frame write/start and mid-frame reset.
module tb_conv_stream_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        wr_sel;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [5:0]  rd_addr;
    logic [35:0] rd_data;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [5:0]  res_count;

    int ncmp     = 0;
    int nerr     = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    conv_stream_driver_if conv ();

    conv_stream_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .conv        (conv.master),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .res_count   (res_count)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a,
                          input logic [35:0] exp);
        rd_addr = a;
        @(negedge clk);
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    // Pulses start, then checks every beat of one frame. Result beats
    // 0x100+(k-lo) are offered on beats lo..hi-1; poke issues a store
    // write and a start request in the middle of the stream.
    task automatic stream(input int lo, input int hi, input bit poke,
                          input bit loaded);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 196; k++) begin
            chk("valid", 64'(conv.conv_in_valid), 64'd1);
            chk("ifm", 64'(conv.conv_ifm), loaded ? 64'(k + 1) : 64'd0);
            chk("weight", 64'(conv.conv_weight),
                (loaded && k < 9) ? 64'(k + 1) : 64'd0);
            chk("busy_send", 64'(busy), 64'd1);
            conv.conv_out_valid = (k >= lo) && (k < hi);
            conv.conv_ofm       = 36'h100 + 36'(k - lo);
            wr_en   = poke && (k == 50 || k == 51);
            wr_sel  = (k == 51);
            wr_addr = (k == 51) ? 8'd3 : 8'd60;
            wr_data = 16'hbeef;
            start   = poke && (k == 50);
            @(negedge clk);
        end
        conv.conv_out_valid = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        chk("valid_drop", 64'(conv.conv_in_valid), 64'd0);
        chk("ifm_idle", 64'(conv.conv_ifm), 64'd0);
        chk("weight_idle", 64'(conv.conv_weight), 64'd0);
    endtask

    initial begin
        int d0;
        int seen;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        rd_addr = '0;
        conv.conv_out_valid = 1'b0;
        conv.conv_ofm       = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(conv.conv_in_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_count", 64'(res_count), 64'd0);
        chk("rst_rd", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load stores, plus out-of-range writes that must be dropped.
        wr_en = 1'b1;
        for (int k = 0; k < 196; k++) begin
            wr_sel = 1'b0; wr_addr = 8'(k); wr_data = 16'(k + 1);
            @(negedge clk);
        end
        for (int k = 0; k < 9; k++) begin
            wr_sel = 1'b1; wr_addr = 8'(k); wr_data = 16'(k + 1);
            @(negedge clk);
        end
        wr_sel = 1'b1; wr_addr = 8'd9; wr_data = 16'h7777;
        @(negedge clk);
        wr_sel = 1'b0; wr_addr = 8'd196; wr_data = 16'h5555;
        @(negedge clk);
        wr_en = 1'b0;

        // Frame 1: stream with mid-frame poke, then 36 gapped results.
        stream(0, 0, 1'b1, 1'b1);
        chk("wait_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 36; i++) begin
            repeat ($urandom_range(0, 99)) @(negedge clk);
            conv.conv_out_valid = 1'b1;
            conv.conv_ofm       = 36'(i + 1);
            @(negedge clk);
            conv.conv_out_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("f1_done_cnt", 64'(done_cnt), 64'd1);
        chk("f1_count", 64'(res_count), 64'd36);
        chk("f1_busy", 64'(busy), 64'd0);
        chk("f1_err", 64'(err_timeout), 64'd0);
        rd_chk("f1_rd35", 6'd35, 36'h000000024);
        rd_chk("f1_rd0", 6'd0, 36'h000000001);
        rd_chk("f1_rd36", 6'd36, 36'h0);
        rd_chk("f1_rd40", 6'd40, 36'h0);

        // Frame 2: replay, 40 results during SEND, completes in SEND.
        d0 = done_cnt;
        stream(10, 50, 1'b0, 1'b1);
        chk("f2_done", 64'(done), 64'd1);
        chk("f2_busy_done", 64'(busy), 64'd1);
        @(negedge clk);
        chk("f2_done_low", 64'(done), 64'd0);
        chk("f2_busy", 64'(busy), 64'd0);
        chk("f2_count", 64'(res_count), 64'd36);
        repeat (2) @(negedge clk);
        chk("f2_done_cnt", 64'(done_cnt - d0), 64'd1);
        rd_chk("f2_rd35", 6'd35, 36'h123);
        rd_chk("f2_rd0", 6'd0, 36'h100);

        // Frame 3: no results, timeout after 1024 WAIT cycles.
        d0 = done_cnt;
        stream(0, 0, 1'b0, 1'b1);
        chk("f3_count", 64'(res_count), 64'd0);
        repeat (1023) @(negedge clk);
        chk("f3_err_early", 64'(err_timeout), 64'd0);
        chk("f3_busy_early", 64'(busy), 64'd1);
        @(negedge clk);
        chk("f3_err", 64'(err_timeout), 64'd1);
        chk("f3_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        chk("f3_no_done", 64'(done_cnt - d0), 64'd0);

        // Frame 4: start clears err, reset at beat 100.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("f4_err_clr", 64'(err_timeout), 64'd0);
        chk("f4_valid", 64'(conv.conv_in_valid), 64'd1);
        repeat (100) @(negedge clk);
        chk("f4_beat100", 64'(conv.conv_ifm), 64'd101);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(conv.conv_in_valid), 64'd0);
        chk("ar_ifm", 64'(conv.conv_ifm), 64'd0);
        chk("ar_weight", 64'(conv.conv_weight), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_err", 64'(err_timeout), 64'd0);
        chk("ar_count", 64'(res_count), 64'd0);
        chk("ar_rd", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (conv.conv_in_valid === 1'b1) seen++;
        end
        chk("ar_no_valid", 64'(seen), 64'd0);
        rd_chk("ar_rd0", 6'd0, 36'h0);

        // Frame 5: cleared stores stream zeros.
        stream(0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
